// File: rtl/hit_memory_reader_if.sv
// Bundle of the query, memory B-port and hit-stream signals of hit_memory_reader.
// master = reader side, slave = storage/consumer side.
interface hit_memory_reader_if #(
    parameter int SSIDBITS         = 12,
    parameter int COLINDEXBITS_HNM = 5,
    parameter int NCOLS_HCM        = 16,
    parameter int ROWINDEXBITS_HIM = 8,
    parameter int HITINFOBITS      = 8,
    parameter int MAXHITS          = 4
) ();
    localparam int NCOLS_HNM = 2 ** COLINDEXBITS_HNM;

    logic                                   memoryBusy;
    logic                                   requestValid;
    logic [SSIDBITS-1:0]                    requestSSID;
    logic                                   requestReady;
    logic [SSIDBITS-COLINDEXBITS_HNM-1:0]   hnmAddr;
    logic [NCOLS_HNM-1:0]                   hnmData;
    logic [SSIDBITS-1:0]                    hcmAddr;
    logic [NCOLS_HCM-1:0]                   hcmData;
    logic [ROWINDEXBITS_HIM-1:0]            himAddr;
    logic [MAXHITS*HITINFOBITS-1:0]         himData;
    logic                                   hitValid;
    logic                                   hitReady;
    logic [HITINFOBITS-1:0]                 hitInfo;
    logic                                   hitLast;
    logic                                   hitEmpty;
    logic                                   countOverflow;
    logic [15:0]                            statRequests;
    logic [15:0]                            statMisses;

    modport master (
        input  memoryBusy, requestValid, requestSSID, hnmData, hcmData, himData, hitReady,
        output requestReady, hnmAddr, hcmAddr, himAddr, hitValid, hitInfo, hitLast,
               hitEmpty, countOverflow, statRequests, statMisses
    );

    modport slave (
        output memoryBusy, requestValid, requestSSID, hnmData, hcmData, himData, hitReady,
        input  requestReady, hnmAddr, hcmAddr, himAddr, hitValid, hitInfo, hitLast,
               hitEmpty, countOverflow, statRequests, statMisses
    );
endinterface

// File: rtl/hit_memory_reader.sv
// Walks HNM -> HCM -> HIM for one SSID and streams its hit words oldest first.
// Optional request/miss counters are built when HIT_READER_STATS_EN is defined.
module hit_memory_reader #(
    parameter int SSIDBITS         = 12,
    parameter int COLINDEXBITS_HNM = 5,
    parameter int NCOLS_HCM        = 16,
    parameter int ROWINDEXBITS_HIM = 8,
    parameter int MAXHITNBITS      = 3,
    parameter int HITINFOBITS      = 8,
    parameter int MAXHITS          = 4
) (
    input  logic                 clock,
    input  logic                 resetN,
    hit_memory_reader_if.master  bus
);
    localparam int IDXW = (MAXHITS > 1) ? $clog2(MAXHITS) : 1;
    localparam logic [MAXHITNBITS-1:0] MAXCOUNT = MAXHITNBITS'(MAXHITS);

    typedef enum logic [2:0] {
        IDLE, HNM_WAIT, HNM_CHK, HCM_WAIT, HCM_CHK, HIM_WAIT, HIM_LOAD, STREAM
    } state_t;

    state_t                               state;
    logic [SSIDBITS-1:0]                  ssid;
    logic [MAXHITNBITS-1:0]               count;
    logic [IDXW-1:0]                      index;
    logic [MAXHITS-1:0][HITINFOBITS-1:0]  row;
    logic [SSIDBITS-COLINDEXBITS_HNM-1:0] hnmAddr;
    logic [SSIDBITS-1:0]                  hcmAddr;
    logic [ROWINDEXBITS_HIM-1:0]          himAddr;
    logic                                 hitValid, hitLast, hitEmpty, countOverflow;
    logic [HITINFOBITS-1:0]               hitInfo;

    logic                                 accept, beatDone, hnmBit, unusedHcmBits;
    logic [MAXHITNBITS-1:0]               hcmCount;
    logic [MAXHITS-1:0][HITINFOBITS-1:0]  himRow;
    logic [IDXW-1:0]                      loadIndex, nextIndex;

    assign accept        = (state == IDLE) && bus.requestValid && !bus.memoryBusy;
    assign beatDone      = hitValid && bus.hitReady;
    assign hnmBit        = bus.hnmData[ssid[COLINDEXBITS_HNM-1:0]];
    assign hcmCount      = bus.hcmData[MAXHITNBITS-1:0];
    assign unusedHcmBits = ^bus.hcmData;
    assign himRow        = bus.himData;
    assign loadIndex     = IDXW'(count - 1'b1);
    assign nextIndex     = index - 1'b1;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state         <= IDLE;
            ssid          <= '0;
            count         <= '0;
            index         <= '0;
            row           <= '0;
            hnmAddr       <= '0;
            hcmAddr       <= '0;
            himAddr       <= '0;
            hitValid      <= 1'b0;
            hitInfo       <= '0;
            hitLast       <= 1'b0;
            hitEmpty      <= 1'b0;
            countOverflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    ssid    <= bus.requestSSID;
                    hnmAddr <= bus.requestSSID[SSIDBITS-1:COLINDEXBITS_HNM];
                    state   <= HNM_WAIT;
                end
                HNM_WAIT: state <= HNM_CHK;
                HNM_CHK: if (!hnmBit) begin
                    hitValid <= 1'b1;
                    hitEmpty <= 1'b1;
                    hitLast  <= 1'b1;
                    hitInfo  <= '0;
                    state    <= STREAM;
                end else begin
                    hcmAddr <= ssid;
                    state   <= HCM_WAIT;
                end
                HCM_WAIT: state <= HCM_CHK;
                HCM_CHK: if (hcmCount == '0) begin
                    // HNM says hit but the count is empty: flag it and answer as a miss
                    countOverflow <= 1'b1;
                    hitValid      <= 1'b1;
                    hitEmpty      <= 1'b1;
                    hitLast       <= 1'b1;
                    hitInfo       <= '0;
                    state         <= STREAM;
                end else begin
                    if (hcmCount > MAXCOUNT) begin
                        count         <= MAXCOUNT;
                        countOverflow <= 1'b1;
                    end else begin
                        count <= hcmCount;
                    end
                    himAddr <= bus.hcmData[NCOLS_HCM-1 -: ROWINDEXBITS_HIM];
                    state   <= HIM_WAIT;
                end
                HIM_WAIT: state <= HIM_LOAD;
                HIM_LOAD: begin
                    // newest hit is slot 0, so start at the highest filled slot
                    row      <= himRow;
                    index    <= loadIndex;
                    hitInfo  <= himRow[loadIndex];
                    hitLast  <= (count == MAXHITNBITS'(1));
                    hitValid <= 1'b1;
                    state    <= STREAM;
                end
                STREAM: if (beatDone) begin
                    if (hitLast) begin
                        hitValid <= 1'b0;
                        hitLast  <= 1'b0;
                        hitEmpty <= 1'b0;
                        hitInfo  <= '0;
                        state    <= IDLE;
                    end else begin
                        index   <= nextIndex;
                        hitInfo <= row[nextIndex];
                        hitLast <= (nextIndex == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HIT_READER_STATS_EN
    logic [15:0] statRequests, statMisses;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            statRequests <= '0;
            statMisses   <= '0;
        end else begin
            if (accept && statRequests != 16'hFFFF) statRequests <= statRequests + 16'd1;
            if (beatDone && hitEmpty && statMisses != 16'hFFFF) statMisses <= statMisses + 16'd1;
        end
    end

    assign bus.statRequests = statRequests;
    assign bus.statMisses   = statMisses;
`else
    assign bus.statRequests = '0;
    assign bus.statMisses   = '0;
`endif

    assign bus.requestReady  = (state == IDLE) && !bus.memoryBusy;
    assign bus.hnmAddr       = hnmAddr;
    assign bus.hcmAddr       = hcmAddr;
    assign bus.himAddr       = himAddr;
    assign bus.hitValid      = hitValid;
    assign bus.hitInfo       = hitInfo;
    assign bus.hitLast       = hitLast;
    assign bus.hitEmpty      = hitEmpty;
    assign bus.countOverflow = countOverflow;
endmodule

// File: tb/tb_hit_memory_reader.sv
// Bench for hit_memory_reader: directed scenarios then random queries against a
// queue-based reference built from the memory contents.
module tb_hit_memory_reader;
    localparam int SSIDBITS = 12, COLB = 5, NCOLS_HCM = 16, ROWB_HIM = 8;
    localparam int MAXHITNBITS = 3, HITINFOBITS = 8, MAXHITS = 4;

    logic clock = 1'b0;
    logic resetN = 1'b0;
    always #5 clock = ~clock;

    hit_memory_reader_if #(.SSIDBITS(SSIDBITS), .COLINDEXBITS_HNM(COLB), .NCOLS_HCM(NCOLS_HCM),
        .ROWINDEXBITS_HIM(ROWB_HIM), .HITINFOBITS(HITINFOBITS), .MAXHITS(MAXHITS)) bus ();

    hit_memory_reader #(.SSIDBITS(SSIDBITS), .COLINDEXBITS_HNM(COLB), .NCOLS_HCM(NCOLS_HCM),
        .ROWINDEXBITS_HIM(ROWB_HIM), .MAXHITNBITS(MAXHITNBITS), .HITINFOBITS(HITINFOBITS),
        .MAXHITS(MAXHITS)) dut (.clock(clock), .resetN(resetN), .bus(bus));

    logic [31:0] hnm [128];
    logic [15:0] hcm [4096];
    logic [31:0] him [256];

    // storage RAMs with one-cycle read latency
    always @(posedge clock) begin
        bus.hnmData <= hnm[bus.hnmAddr];
        bus.hcmData <= hcm[bus.hcmAddr];
        bus.himData <= him[bus.himAddr];
    end

    int checks = 0, passed = 0, fails = 0;
    int expReq = 0, expMiss = 0, expLat = 0;
    logic expOvf = 1'b0;
    logic [10:0] expQ [$];   // {valid, empty, last, info}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic buildModel(input logic [11:0] s);
        logic [15:0] h;
        int c;
        expQ.delete();
        if (!hnm[s[11:5]][s[4:0]]) begin
            expQ.push_back({1'b1, 1'b1, 1'b1, 8'h00});
            expLat = 2;
        end else begin
            h = hcm[s];
            c = int'(h[2:0]);
            if (c == 0) begin
                expOvf = 1'b1;
                expQ.push_back({1'b1, 1'b1, 1'b1, 8'h00});
                expLat = 4;
            end else begin
                if (c > MAXHITS) begin
                    c = MAXHITS;
                    expOvf = 1'b1;
                end
                expLat = 6;
                for (int k = c - 1; k >= 0; k--)
                    expQ.push_back({1'b1, 1'b0, (k == 0), him[h[15:8]][k*8 +: 8]});
            end
        end
    endtask

    task automatic issue(input logic [11:0] s, input string tag);
        int cyc = 0;
        while (!bus.requestReady && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        check({tag, "_reqReady"}, 32'(bus.requestReady), 32'd1);
        bus.requestValid = 1'b1;
        bus.requestSSID  = s;
        @(posedge clock);
        @(negedge clock);
        bus.requestValid = 1'b0;
        expReq++;
        check({tag, "_hnmAddr"}, 32'(bus.hnmAddr), 32'(s[11:5]));
    endtask

    // entered at the negedge right after the acceptance edge
    task automatic waitAndDrain(input string tag, input int mode);
        int k = 0, n = 0, cyc = 0;
        logic rdy;
        while (!bus.hitValid && k < 20) begin
            @(posedge clock);
            @(negedge clock);
            k++;
        end
        check({tag, "_latency"}, 32'(k), 32'(expLat));
        while (n < expQ.size() && cyc < 200) begin
            check({tag, "_beat"}, 32'({bus.hitValid, bus.hitEmpty, bus.hitLast, bus.hitInfo}),
                  32'(expQ[n]));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 5 == 0) || (cyc % 5 == 3) || (cyc % 5 == 4);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.hitReady = rdy;
            if (rdy) begin
                if (expQ[n][9]) expMiss++;
                n++;
            end
            @(posedge clock);
            @(negedge clock);
            cyc++;
        end
        bus.hitReady = 1'b0;
        check({tag, "_beatCount"}, 32'(n), 32'(expQ.size()));
        check({tag, "_idleAfter"}, 32'({bus.hitValid, bus.requestReady}), 32'b01);
        check({tag, "_overflow"}, 32'(bus.countOverflow), 32'(expOvf));
    endtask

    task automatic runReq(input logic [11:0] s, input int mode, input string tag);
        buildModel(s);
        issue(s, tag);
        waitAndDrain(tag, mode);
    endtask

    initial begin
        foreach (hnm[i]) hnm[i] = '0;
        foreach (hcm[i]) hcm[i] = '0;
        foreach (him[i]) him[i] = '0;
        bus.memoryBusy = 1'b0;
        bus.requestValid = 1'b0;
        bus.requestSSID = '0;
        bus.hitReady = 1'b0;

        repeat (2) @(negedge clock);
        check("rst_outputs", 32'({bus.hitValid, bus.hitInfo, bus.hitLast, bus.hitEmpty,
              bus.countOverflow}), 32'd0);
        check("rst_addrs", 32'({bus.hnmAddr, bus.hcmAddr, bus.himAddr}), 32'd0);
        check("rst_stats", {bus.statRequests, bus.statMisses}, 32'd0);
        check("rst_ready", 32'(bus.requestReady), 32'd1);
        bus.memoryBusy = 1'b1;
        #1 check("rst_ready_busy", 32'(bus.requestReady), 32'd0);
        bus.memoryBusy = 1'b0;
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);

        runReq(12'h025, 0, "miss");
        hnm[1][5] = 1'b1;
        hcm[12'h025] = 16'h0703;
        him[7] = 32'h00CCBBAA;
        runReq(12'h025, 0, "hit3");
        runReq(12'h025, 1, "stall");
        hcm[12'h025] = 16'h0707;
        him[7] = 32'hDDCCBBAA;
        runReq(12'h025, 0, "ovf7");
        hcm[12'h025] = 16'h0703;
        runReq(12'h025, 0, "ovfSticky");

        // memoryBusy holds off acceptance
        bus.memoryBusy = 1'b1;
        bus.requestValid = 1'b1;
        bus.requestSSID = 12'h3E0;
        buildModel(12'h3E0);
        repeat (3) begin
            @(posedge clock);
            @(negedge clock);
            check("busy_hold", 32'({bus.requestReady, bus.hnmAddr}), 32'({1'b0, 7'h01}));
        end
        bus.memoryBusy = 1'b0;
        @(posedge clock);
        @(negedge clock);
        bus.requestValid = 1'b0;
        expReq++;
        check("busy_accept", 32'(bus.hnmAddr), 32'h1F);
        waitAndDrain("busy", 0);

        // reset during beat 2 of 3
        buildModel(12'h025);
        issue(12'h025, "abort");
        begin
            int k = 0;
            while (!bus.hitValid && k < 20) begin
                @(posedge clock);
                @(negedge clock);
                k++;
            end
        end
        bus.hitReady = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("abort_beat2", 32'({bus.hitValid, bus.hitLast, bus.hitInfo}), 32'({2'b10, 8'hBB}));
        resetN = 1'b0;
        #1;
        check("abort_outputs", 32'({bus.hitValid, bus.hitLast, bus.requestReady, bus.countOverflow}),
              32'b0010);
        expOvf = 1'b0;
        expReq = 0;
        expMiss = 0;
        bus.hitReady = 1'b0;
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
        runReq(12'h025, 0, "afterRst");

        // random memory contents and queries
        foreach (hnm[i]) hnm[i] = $urandom;
        foreach (hcm[i]) hcm[i] = 16'($urandom);
        foreach (him[i]) him[i] = $urandom;
        for (int r = 0; r < 40; r++)
            runReq(12'($urandom), (r % 4 == 0) ? 0 : 2, "rand");

`ifdef HIT_READER_STATS_EN
        check("stats", {bus.statRequests, bus.statMisses}, {16'(expReq), 16'(expMiss)});
`else
        check("stats", {bus.statRequests, bus.statMisses}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
